// File: rtl/key_pkg.sv
// Shared types and helpers for the key arbiter.
//   state_e  : arbiter FSM states
//   idx_w    : width of a key index for a given key count (minimum 1)
//   wrap_inc : round-robin increment with explicit wrap, valid for any key count
package key_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_OFFER
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // Explicit wrap so non-power-of-two key counts skip the unused index values.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/key_arbiter_if.sv
// Key/command bundle between the key conditioning, the arbiter and the consumer.
//   keyIn    : synchronized level key inputs
//   cmdReady : consumer accepts the offered command
//   cmdValid : command offered
//   cmdKey   : index of the offered key
//   pending  : latched, not-yet-accepted press events
//   overrun  : sticky, a press was merged into an already-pending event
// master = arbiter side, slave = stimulus/consumer side.
interface key_arbiter_if
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS = 4
);
    localparam int unsigned IDX_W = idx_w(N_KEYS);

    logic [N_KEYS-1:0] keyIn;
    logic              cmdReady;
    logic              cmdValid;
    logic [IDX_W-1:0]  cmdKey;
    logic [N_KEYS-1:0] pending;
    logic              overrun;

    modport master (
        input  keyIn,
        input  cmdReady,
        output cmdValid,
        output cmdKey,
        output pending,
        output overrun
    );

    modport slave (
        output keyIn,
        output cmdReady,
        input  cmdValid,
        input  cmdKey,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one synchronized key.
//   clk   : system clock
//   reset : synchronous active-high reset
//   keyIn : level key input
//   press : one-cycle pulse when keyIn goes 0 -> 1
// Reset loads the previous-value flop with the live input so a key held through
// reset produces no press afterwards.
module key_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic keyIn,
    output logic press
);
    logic key_prev_q;
    logic key_prev_d;

    always_comb begin
        key_prev_d = keyIn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= keyIn;
        end else begin
            key_prev_q <= key_prev_d;
        end
    end

    assign press = keyIn & ~key_prev_q;
endmodule

// File: rtl/key_arbiter.sv
// Turns key press events into single commands and offers them one at a time to
// a shared consumer over valid/ready, using round-robin priority.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   cmd_if : key inputs, command handshake, pending vector and overrun flag
module key_arbiter
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS = 4
) (
    input  logic          clk,
    input  logic          reset,
    key_arbiter_if.master cmd_if
);
    localparam int unsigned IDX_W = idx_w(N_KEYS);

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] acc_vec;
    logic              accept;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    state_e            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [IDX_W-1:0]  cmd_key_q, cmd_key_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic              overrun_q, overrun_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : gen_edge
        key_edge_detect u_edge (
            .clk   (clk),
            .reset (reset),
            .keyIn (cmd_if.keyIn[i]),
            .press (press[i])
        );
    end

    assign accept = cmd_valid_q & cmd_if.cmdReady;

    // A press coinciding with its own accept is a fresh event: the bit stays set
    // and it does not count as an overrun.
    always_comb begin
        acc_vec   = accept ? (N_KEYS'(1) << cmd_key_q) : '0;
        pending_d = press | (pending_q & ~acc_vec);
        overrun_d = overrun_q | (|(press & pending_q & ~acc_vec));
    end

    // Round-robin scan of the registered pending vector, starting after lastGrant.
    always_comb begin
        logic [IDX_W-1:0] scan;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = last_grant_q;
        for (int k = 0; k < N_KEYS; k++) begin
            scan = IDX_W'(wrap_inc(32'(scan), N_KEYS));
            if (!pick_found && pending_q[scan]) begin
                pick_found = 1'b1;
                pick_idx   = scan;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_key_d    = cmd_key_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    cmd_key_d   = pick_idx;
                    cmd_valid_d = 1'b1;
                    state_d     = S_OFFER;
                end
            end
            S_OFFER: begin
                if (accept) begin
                    last_grant_d = cmd_key_q;
                    cmd_valid_d  = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_key_q    <= '0;
            last_grant_q <= IDX_W'(N_KEYS - 1);
            pending_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_key_q    <= cmd_key_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cmd_if.cmdValid = cmd_valid_q;
    assign cmd_if.cmdKey   = cmd_key_q;
    assign cmd_if.pending  = pending_q;
    assign cmd_if.overrun  = overrun_q;
endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter with N_KEYS=4. Expected commands are queued as
// stimulus is issued; a negedge monitor pops and compares on every accept.
module tb_key_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_q[$];

    key_arbiter_if #(.N_KEYS(4)) bus ();

    key_arbiter #(.N_KEYS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .cmd_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] k);
        reset        = 1'b1;
        bus.keyIn    = k;
        bus.cmdReady = 1'b0;
        step(2);
        chk("rst_valid", 32'(bus.cmdValid), 0);
        chk("rst_key", 32'(bus.cmdKey), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every accept must match the next queued command, and
    // the offered key must not change while stalled.
    logic       hold_q;
    logic [1:0] hold_key;
    initial hold_q = 1'b0;
    always @(negedge clk) begin
        if (!reset && hold_q && bus.cmdValid) begin
            chk("key_stable", 32'(bus.cmdKey), 32'(hold_key));
        end
        if (!reset && bus.cmdValid && bus.cmdReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 32'(bus.cmdKey), 32'hFFFF);
            end else begin
                chk("cmd_key", 32'(bus.cmdKey), 32'(exp_q.pop_front()));
            end
        end
        hold_q   = !reset && bus.cmdValid && !bus.cmdReady;
        hold_key = bus.cmdKey;
    end

    logic [3:0] t3_pend [7];
    logic       t3_val  [7];

    initial begin
        checks = 0;
        errors = 0;
        t3_pend = '{4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
        t3_val  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // 1: key held through reset gives no event
        do_reset(4'b0010);
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk("t1_pending", 32'(bus.pending), 0);
            chk("t1_valid", 32'(bus.cmdValid), 0);
        end
        chk("t1_overrun", 32'(bus.overrun), 0);
        bus.keyIn = 4'b0000;
        step(2);

        // 2: single press, latency and no repeat while held
        do_reset(4'b0000);
        bus.cmdReady = 1'b1;
        bus.keyIn = 4'b0100;
        exp_q.push_back(2);
        step(1);
        chk("t2_pending", 32'(bus.pending), 32'h4);
        chk("t2_valid0", 32'(bus.cmdValid), 0);
        step(1);
        chk("t2_valid1", 32'(bus.cmdValid), 1);
        chk("t2_key", 32'(bus.cmdKey), 2);
        step(1);
        chk("t2_pending_clr", 32'(bus.pending), 0);
        chk("t2_valid_clr", 32'(bus.cmdValid), 0);
        for (int c = 0; c < 8; c++) begin
            step(1);
            chk("t2_no_repeat", 32'(bus.cmdValid), 0);
        end
        bus.keyIn = 4'b0000;
        step(2);
        chk("t2_queue", 32'(exp_q.size()), 0);

        // 3: simultaneous presses served 0, 1, 3 two cycles apart
        do_reset(4'b0000);
        bus.cmdReady = 1'b1;
        bus.keyIn = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        for (int c = 0; c < 7; c++) begin
            step(1);
            chk("t3_pending", 32'(bus.pending), 32'(t3_pend[c]));
            chk("t3_valid", 32'(bus.cmdValid), 32'(t3_val[c]));
        end
        bus.keyIn = 4'b0000;
        step(2);
        chk("t3_queue", 32'(exp_q.size()), 0);

        // 4: fairness after key 1 granted
        do_reset(4'b0000);
        bus.cmdReady = 1'b1;
        bus.keyIn = 4'b0010;
        exp_q.push_back(1);
        step(3);
        bus.keyIn = 4'b0101;
        exp_q.push_back(2);
        exp_q.push_back(0);
        step(1);
        chk("t4_pending", 32'(bus.pending), 32'h5);
        step(1);
        chk("t4_first", 32'(bus.cmdKey), 2);
        step(2);
        chk("t4_second", 32'(bus.cmdKey), 0);
        chk("t4_second_v", 32'(bus.cmdValid), 1);
        step(1);
        chk("t4_pending_end", 32'(bus.pending), 0);
        bus.keyIn = 4'b0000;
        step(2);
        chk("t4_queue", 32'(exp_q.size()), 0);

        // 5: backpressure with a new press during the stall
        do_reset(4'b0000);
        bus.keyIn = 4'b0010;
        exp_q.push_back(1);
        step(2);
        chk("t5_offer", 32'(bus.cmdKey), 1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.keyIn = 4'b1010;
                exp_q.push_back(3);
            end
            step(1);
        end
        chk("t5_hold_key", 32'(bus.cmdKey), 1);
        chk("t5_hold_valid", 32'(bus.cmdValid), 1);
        chk("t5_pending", 32'(bus.pending), 32'hA);
        bus.cmdReady = 1'b1;
        step(1);
        chk("t5_after_acc", 32'(bus.pending), 32'h8);
        step(1);
        chk("t5_next_key", 32'(bus.cmdKey), 3);
        step(1);
        chk("t5_pending_end", 32'(bus.pending), 0);
        bus.keyIn = 4'b0000;
        step(2);
        chk("t5_queue", 32'(exp_q.size()), 0);

        // 6a: repeated press while pending merges and sets overrun
        do_reset(4'b0000);
        bus.keyIn = 4'b0010;
        exp_q.push_back(1);
        step(2);
        bus.keyIn = 4'b0000;
        step(1);
        chk("t6a_overrun0", 32'(bus.overrun), 0);
        bus.keyIn = 4'b0010;
        step(1);
        chk("t6a_overrun1", 32'(bus.overrun), 1);
        chk("t6a_pending", 32'(bus.pending), 32'h2);
        bus.cmdReady = 1'b1;
        step(6);
        chk("t6a_sticky", 32'(bus.overrun), 1);
        chk("t6a_pending_end", 32'(bus.pending), 0);
        chk("t6a_queue", 32'(exp_q.size()), 0);

        // 6b: press coinciding with its own accept is a new event, not an overrun
        do_reset(4'b0000);
        bus.cmdReady = 1'b1;
        bus.keyIn = 4'b0010;
        exp_q.push_back(1);
        step(1);
        bus.keyIn = 4'b0000;
        step(1);
        bus.keyIn = 4'b0010;
        exp_q.push_back(1);
        step(1);
        chk("t6b_pending", 32'(bus.pending), 32'h2);
        chk("t6b_overrun", 32'(bus.overrun), 0);
        chk("t6b_valid", 32'(bus.cmdValid), 0);
        step(4);
        chk("t6b_pending_end", 32'(bus.pending), 0);
        chk("t6b_overrun_end", 32'(bus.overrun), 0);
        chk("t6b_queue", 32'(exp_q.size()), 0);

        // Reset during an offer discards the command
        do_reset(4'b0000);
        bus.keyIn = 4'b0001;
        step(2);
        chk("t7_offer", 32'(bus.cmdValid), 1);
        do_reset(4'b0001);
        bus.cmdReady = 1'b1;
        step(4);
        chk("t7_valid", 32'(bus.cmdValid), 0);
        chk("t7_pending", 32'(bus.pending), 0);
        chk("t7_queue", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_arbiter.md
Name: key_arbiter

Overview:
- Collects press events from N_KEYS synchronized key inputs and turns each press into exactly one command.
- Issues commands one at a time to a single shared consumer (game/display logic) over a valid/ready handshake, using round-robin priority.
- Sits between the per-key input conditioning and the consumer, replacing ad-hoc per-key pulse holders.

Parameters:
- N_KEYS, 4, number of key inputs; any value >= 2, power of two not required.
- IDX_W, $clog2(N_KEYS), width of the key index. Derived; do not override.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- keyIn  input  N_KEYS  level key inputs, active-high, already synchronized to clk.
- cmdReady  input  1  consumer accepts the offered command this cycle.
- cmdValid  output  1  command offered (registered).
- cmdKey  output  IDX_W  index of the offered key (registered).
- pending  output  N_KEYS  latched, not-yet-accepted press events, including the one currently offered.
- overrun  output  1  sticky flag: a press was merged into an already-pending event.

Behaviour:
- Edge detect per key: keyPrev[i] is registered every cycle. press[i] = keyIn[i] & ~keyPrev[i]. A held key generates one press only.
- During reset, keyPrev is loaded with keyIn, so a key held through reset produces no event after reset deasserts.
- Reset values: cmdValid=0, cmdKey=0, pending=0, overrun=0, state=S_IDLE, lastGrant=N_KEYS-1 (key 0 has first priority).
- accept = cmdValid & cmdReady.
- pending[i] next state:
  - Set on press[i].
  - Cleared on accept when cmdKey==i.
  - If press[i] and accept of i occur in the same cycle, pending[i] stays 1: it is a new event, and overrun is not set.
- Overrun: press[i] while pending[i]=1 and i is not being accepted sets overrun=1 until reset. The extra press is dropped (merged).
- FSM states:
  - S_IDLE: cmdValid=0. If pending != 0, pick the first set bit scanning lastGrant+1, lastGrant+2, ... with wrap modulo N_KEYS (explicit wrap, not power-of-two masking). Register it to cmdKey, set cmdValid=1, go to S_OFFER. Otherwise stay.
  - S_OFFER: cmdValid=1. cmdKey is held stable until accept. On accept: lastGrant<=cmdKey, cmdValid<=0, go to S_IDLE.
- Only the registered pending vector is scanned in S_IDLE. A press in the same cycle is seen one cycle later.
- Timing: keyIn first sampled high at edge t gives pending[i]=1 after t and cmdValid=1 after t+1. With cmdReady=1, accept happens at t+2. Minimum spacing between commands is 2 cycles (1 offer + 1 idle).
- Backpressure: cmdReady may stay low indefinitely. New presses accumulate in pending, and the offer does not change.
- cmdReady is ignored while cmdValid=0.
- Reset mid-offer: all state is discarded, including pending and the offered command.

Decomposition:
- Shared package key_pkg:
  - state enum {S_IDLE, S_OFFER}.
  - Index-width helper function.
  - Wrap-increment function for the round-robin index.
- One natural sub-module: key_edge_detect (1 bit; clk, reset, keyIn -> press, with the reset-loads-prev rule). Instantiate it N_KEYS times with a generate loop.
- The round-robin pick stays inline.

Test Plan (N_KEYS=4):
1. Reset held with keyIn=4'b0010, then released and keyIn held 5 more cycles -> pending=0, cmdValid=0 throughout, overrun=0.
2. keyIn[2] rises at edge t, held 10 cycles, cmdReady=1 -> pending=4'b0100 after t; cmdValid=1, cmdKey=2 after t+1; accept at t+2; then pending=0, cmdValid=0; no second command.
3. Keys 0, 1, 3 rise in the same cycle, cmdReady=1 -> commands 0, 1, 3 in that order, offers 2 cycles apart; pending goes 1011 -> 1010 -> 1000 -> 0000.
4. Fairness: after key 1 is accepted (lastGrant=1), keys 0 and 2 are pending -> cmdKey=2 first, then 0.
5. Backpressure: key 1 offered, cmdReady=0 for 5 cycles, key 3 pressed during that window -> cmdKey stays 1 and pending=4'b1010. After cmdReady=1: accept key 1, then key 3.
6. Overrun/merge:
   - Key 1 pending, cmdReady=0, key 1 released and pressed again -> overrun=1 (sticky), only one key-1 command results.
   - Separately, a key-1 press in the same cycle as a key-1 accept -> pending[1] stays 1, a second key-1 command follows, overrun stays 0.
